// File: rtl/sampdacfeed.sv
// rtl/sampdacfeed.sv - unpacks 72-bit sample entries (9x8/6x12/12x6) into 8-bit DAC codes
// Optional underrun counter at adr 6: define SAMPDACFEED_UNDERRUN_CNT_EN.
module sampdacfeed #(
  parameter int SAMPLE_W = 72
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sq_active,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [7:0]          dac_out,
  output logic                dac_strobe,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [15:0]         wb_adr_i,
  input  logic [7:0]          wb_dat_i,
  output logic [7:0]          wb_dat_o,
  output logic                wb_ack_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PLAY} state_t;

  state_t        state;
  logic [71:0]   sr;
  logic [7:0]    hold_ctr;
  logic [3:0]    field_idx;
  logic          underrun;
  logic          enable;
  logic [1:0]    mode;
  logic [7:0]    hold_cnt;
  logic [15:0]   offset;
  logic [2:0]    out_shift;

  logic [71:0]   sr_rot;
  logic [3:0]    nfields;
  logic          last_hold;
  logic          last_field;
  logic          end_of_entry;
  logic          underrun_evt;
  logic          wb_wr;
  logic          cfg_wr;

  // Mode 3 is treated as 9x8 everywhere through the default branches.
  function automatic logic [11:0] field_of(input logic [71:0] v, input logic [1:0] m);
    case (m)
      2'd1:    field_of = v[71:60];
      2'd2:    field_of = {6'd0, v[71:66]};
      default: field_of = {4'd0, v[71:64]};
    endcase
  endfunction

  function automatic logic [71:0] rotate(input logic [71:0] v, input logic [1:0] m);
    case (m)
      2'd1:    rotate = {v[59:0], v[71:60]};
      2'd2:    rotate = {v[65:0], v[71:66]};
      default: rotate = {v[63:0], v[71:64]};
    endcase
  endfunction

  function automatic logic [7:0] conv(input logic [11:0] f, input logic [15:0] ofs,
                                      input logic [2:0] sh);
    logic signed [16:0] s;
    logic [15:0]        t;
    s = $signed({5'd0, f}) + $signed({ofs[15], ofs});
    t = s[15:0] >> sh;
    if (s[16])
      conv = 8'h00;
    else if (t > 16'd255)
      conv = 8'hFF;
    else
      conv = t[7:0];
  endfunction

  always_comb begin
    sr_rot = rotate(sr, mode);
    case (mode)
      2'd1:    nfields = 4'd6;
      2'd2:    nfields = 4'd12;
      default: nfields = 4'd9;
    endcase
    last_hold    = (hold_ctr == hold_cnt);
    last_field   = (field_idx == nfields - 4'd1);
    end_of_entry = (state == ST_PLAY) && last_hold && last_field;
    sample_ready = sq_active && ((state == ST_WAIT) || end_of_entry);
    underrun_evt = sq_active && end_of_entry && !sample_valid;
    wb_wr        = wb_stb_i && wb_cyc_i && wb_we_i;
    cfg_wr       = wb_wr && !sq_active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sr         <= '0;
      hold_ctr   <= '0;
      field_idx  <= '0;
      dac_out    <= '0;
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
      enable     <= 1'b0;
      mode       <= '0;
      hold_cnt   <= '0;
      offset     <= '0;
      out_shift  <= '0;
    end else begin
      dac_strobe <= 1'b0;
      if (cfg_wr) begin
        case (wb_adr_i[2:0])
          3'd0: begin
            enable <= wb_dat_i[0];
            mode   <= wb_dat_i[5:4];
            if (wb_dat_i[7]) underrun <= 1'b0;
          end
          3'd1:    hold_cnt     <= wb_dat_i;
          3'd2:    offset[7:0]  <= wb_dat_i;
          3'd3:    offset[15:8] <= wb_dat_i;
          3'd4:    out_shift    <= wb_dat_i[2:0];
          default: ;
        endcase
      end
      if (!sq_active) begin
        state     <= ST_IDLE;
        hold_ctr  <= '0;
        field_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: if (enable) state <= ST_WAIT;
          ST_WAIT: begin
            if (sample_valid) begin
              sr         <= sample[71:0];
              field_idx  <= '0;
              hold_ctr   <= '0;
              state      <= ST_PLAY;
              dac_out    <= conv(field_of(sample[71:0], mode), offset, out_shift);
              dac_strobe <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (!last_hold) begin
              hold_ctr <= hold_ctr + 8'd1;
            end else if (!last_field) begin
              sr         <= sr_rot;
              field_idx  <= field_idx + 4'd1;
              hold_ctr   <= '0;
              dac_out    <= conv(field_of(sr_rot, mode), offset, out_shift);
              dac_strobe <= 1'b1;
            end else if (sample_valid) begin
              sr         <= sample[71:0];
              field_idx  <= '0;
              hold_ctr   <= '0;
              dac_out    <= conv(field_of(sample[71:0], mode), offset, out_shift);
              dac_strobe <= 1'b1;
            end else begin
              state    <= ST_WAIT;
              underrun <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SAMPDACFEED_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;

  // Clearing is allowed even during playback, unlike the other registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      underrun_cnt <= '0;
    else if (wb_wr && wb_adr_i[2:0] == 3'd6)
      underrun_cnt <= '0;
    else if (underrun_evt && underrun_cnt != 8'hFF)
      underrun_cnt <= underrun_cnt + 8'd1;
  end
`else
  logic [7:0] underrun_cnt;
  assign underrun_cnt = 8'h00;
  logic unused_evt;
  assign unused_evt = underrun_evt;
`endif

  always_comb begin
    case (wb_adr_i[2:0])
      3'd0:    wb_dat_o = {underrun, 1'b0, mode, 3'b000, enable};
      3'd1:    wb_dat_o = hold_cnt;
      3'd2:    wb_dat_o = offset[7:0];
      3'd3:    wb_dat_o = offset[15:8];
      3'd4:    wb_dat_o = {5'd0, out_shift};
      3'd6:    wb_dat_o = underrun_cnt;
      default: wb_dat_o = 8'h00;
    endcase
  end

  assign wb_ack_o = 1'b1;

  logic unused_adr;
  assign unused_adr = &{1'b0, wb_adr_i[15:3]};

endmodule
